// File: rtl/uart_autobaud_detector_if.sv
// Control/result bundle between the autobaud detector and its host.
// master = host that arms the detector; slave = the detector itself.
interface uart_autobaud_detector_if #(
    parameter int CNT_WIDTH = 32
);
    logic                 arm;
    logic                 busy;
    logic                 valid;
    logic                 error;
    logic [CNT_WIDTH-1:0] bit_period;
    logic [CNT_WIDTH-1:0] divisor;

    modport master (
        output arm,
        input  busy, valid, error, bit_period, divisor
    );

    modport slave (
        input  arm,
        output busy, valid, error, bit_period, divisor
    );
endinterface

// File: rtl/uart_autobaud_detector.sv
// Measures the bit period of a 0x55 sync character on rx and derives the
// half-period divisor for a runtime-loadable baud generator.
//
// state      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | not armed, outputs hold last result
// S_WAIT_HIGH| armed, waiting for the line to be idle-high
// S_WAIT_START| waiting for the start-bit falling edge (E1)
// S_MEASURE  | timing intervals I1..I4 between falling edges E1..E5
// S_STOP     | waiting for the stop-bit rising edge after E5
// S_DONE     | one cycle: publish result or flag a zero divisor
module uart_autobaud_detector #(
    parameter int CLOCK_RATE   = 200_000_000,
    parameter int OVERSAMPLE   = 16,
    parameter int CNT_WIDTH    = 32,
    parameter int TIMEOUT_CLKS = 16_777_216,
    parameter int TOL_SHIFT    = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_rx,
    uart_autobaud_detector_if.slave bus
);

    localparam int                   DIV_SHIFT = $clog2(2 * OVERSAMPLE);
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_V = CNT_WIDTH'(TIMEOUT_CLKS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_HIGH,
        S_WAIT_START,
        S_MEASURE,
        S_STOP,
        S_DONE
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;

    logic                   r_rx_meta;
    logic                   r_rx_sync;
    logic                   r_rx_prev;
    logic                   w_fall;
    logic                   w_rise;

    logic [CNT_WIDTH-1:0]   r_cnt;
    logic [CNT_WIDTH-1:0]   w_cnt_nxt;
    logic [CNT_WIDTH+2:0]   r_total;
    logic [CNT_WIDTH+2:0]   w_total_nxt;
    logic [CNT_WIDTH-1:0]   r_i1;
    logic [CNT_WIDTH-1:0]   w_i1_nxt;
    logic [2:0]             r_edge_cnt;
    logic [2:0]             w_edge_nxt;

    logic [CNT_WIDTH-1:0]   r_bit_period;
    logic [CNT_WIDTH-1:0]   w_bp_nxt;
    logic [CNT_WIDTH-1:0]   r_divisor;
    logic [CNT_WIDTH-1:0]   w_div_nxt;
    logic                   r_valid;
    logic                   w_valid_nxt;
    logic                   r_error;
    logic                   w_error_nxt;
    logic                   r_busy;

    logic [CNT_WIDTH-1:0]   w_diff;
    logic                   w_out_of_tol;
    logic [CNT_WIDTH-1:0]   w_bp_calc;
    logic [CNT_WIDTH-1:0]   w_div_calc;

    assign w_fall = r_rx_prev & ~r_rx_sync;
    assign w_rise = ~r_rx_prev & r_rx_sync;

    assign w_diff       = (r_cnt >= r_i1) ? (r_cnt - r_i1) : (r_i1 - r_cnt);
    assign w_out_of_tol = w_diff > (r_i1 >> TOL_SHIFT);

    // total spans 8 bit times, so >>3 is one bit and a further shift gives the half-period
    assign w_bp_calc  = r_total[CNT_WIDTH+2:3];
    assign w_div_calc = w_bp_calc >> DIV_SHIFT;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_total_nxt = r_total;
        w_i1_nxt    = r_i1;
        w_edge_nxt  = r_edge_cnt;
        w_bp_nxt    = r_bit_period;
        w_div_nxt   = r_divisor;
        w_valid_nxt = 1'b0;
        w_error_nxt = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.arm) w_state_nxt = S_WAIT_HIGH;
            end
            S_WAIT_HIGH: begin
                if (r_rx_sync) w_state_nxt = S_WAIT_START;
            end
            S_WAIT_START: begin
                if (w_fall) begin
                    w_state_nxt = S_MEASURE;
                    w_cnt_nxt   = CNT_ONE;
                    w_total_nxt = '0;
                    w_edge_nxt  = 3'd1;
                end
            end
            S_MEASURE: begin
                w_cnt_nxt = r_cnt + CNT_ONE;
                if (w_fall) begin
                    w_total_nxt = r_total + {3'b000, r_cnt};
                    w_cnt_nxt   = CNT_ONE;
                    w_edge_nxt  = r_edge_cnt + 3'd1;
                    if (r_edge_cnt == 3'd1) w_i1_nxt = r_cnt;
                    if ((r_edge_cnt >= 3'd2) && w_out_of_tol) begin
                        w_error_nxt = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (r_edge_cnt == 3'd4) begin
                        w_state_nxt = S_STOP;
                    end
                end else if (r_cnt >= TIMEOUT_V) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_STOP: begin
                w_cnt_nxt = r_cnt + CNT_ONE;
                if (w_rise && (r_cnt <= r_i1)) begin
                    w_state_nxt = S_DONE;
                end else if ((r_cnt >= r_i1) || (r_cnt >= TIMEOUT_V)) begin
                    w_error_nxt = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
                if (w_div_calc == '0) begin
                    w_error_nxt = 1'b1;
                end else begin
                    w_valid_nxt = 1'b1;
                    w_bp_nxt    = w_bp_calc;
                    w_div_nxt   = w_div_calc;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Re-arm abandons the current attempt silently; a result completing in DONE still publishes.
        if (bus.arm && (r_state != S_IDLE)) begin
            w_state_nxt = S_WAIT_HIGH;
            w_error_nxt = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_meta    <= 1'b1;
            r_rx_sync    <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_total      <= '0;
            r_i1         <= '0;
            r_edge_cnt   <= '0;
            r_bit_period <= '0;
            r_divisor    <= '0;
            r_valid      <= 1'b0;
            r_error      <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_rx_meta    <= i_rx;
            r_rx_sync    <= r_rx_meta;
            r_rx_prev    <= r_rx_sync;
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_total      <= w_total_nxt;
            r_i1         <= w_i1_nxt;
            r_edge_cnt   <= w_edge_nxt;
            r_bit_period <= w_bp_nxt;
            r_divisor    <= w_div_nxt;
            r_valid      <= w_valid_nxt;
            r_error      <= w_error_nxt;
            // busy stays up through the valid/error cycle and drops on the next one
            r_busy       <= (w_state_nxt != S_IDLE) | w_valid_nxt | w_error_nxt;
        end
    end

    assign bus.busy       = r_busy;
    assign bus.valid      = r_valid;
    assign bus.error      = r_error;
    assign bus.bit_period = r_bit_period;
    assign bus.divisor    = r_divisor;

endmodule
